// File: rtl/ftdi_pkg.sv
// Shared definitions for the FTDI FT245 bridges: FSM state encoding and the
// width of the shared cycle timer.
package ftdi_pkg;

    localparam int unsigned TmrW   = 4;
    localparam int unsigned TmrMax = (1 << TmrW) - 1;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLoad,
        StWait,
        StSetup,
        StStrobe,
        StHold,
        StFlush
    } ftdi_tx_state_t;

endpackage

// File: rtl/ftdi_tmr.sv
// Loadable down-counter; o_done is high once the count has reached zero.
module ftdi_tmr
    import ftdi_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            i_load,
    input  logic [TmrW-1:0] i_val,
    output logic            o_done
);

    logic [TmrW-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_done = (r_cnt == '0);

endmodule

// File: rtl/ftdi_tx.sv
// Drains a 1-cycle-latency FIFO onto an FT245-style parallel write port, with
// overlapped fetch on the hold cycle, idle/requested siwu_n flush and a word counter.
module ftdi_tx
    import ftdi_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned SETUP_CYC = 1,
    parameter int unsigned WR_PULSE  = 1,
    parameter int unsigned SIWU_IDLE = 64,
    parameter int unsigned CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              empty,
    output logic              rd_en,
    input  logic [DATA_W-1:0] din,
    input  logic              txe_n,
    input  logic              flush_req,
    output logic              wr_n,
    output logic              siwu_n,
    output logic [DATA_W-1:0] dout,
    output logic              dout_oe,
    output logic              busy,
    output logic [CNT_W-1:0]  tx_count
);

    localparam int unsigned IdleW = (SIWU_IDLE > 0) ? $clog2(SIWU_IDLE + 1) : 1;
    localparam logic [IdleW-1:0] IdleMax  = IdleW'(SIWU_IDLE);
    localparam logic [IdleW-1:0] IdleLast = (SIWU_IDLE > 0) ? IdleW'(SIWU_IDLE - 1) : '0;
    localparam logic [TmrW-1:0]  SetupLd  = (SETUP_CYC > 0) ? TmrW'(SETUP_CYC - 1) : '0;
    localparam logic [TmrW-1:0]  PulseLd  = (WR_PULSE > 0) ? TmrW'(WR_PULSE - 1) : '0;

    if (SETUP_CYC > TmrMax) begin : g_bad_setup
        $error("ftdi_tx: SETUP_CYC must be 0..15");
    end
    if (WR_PULSE < 1 || WR_PULSE > TmrMax) begin : g_bad_pulse
        $error("ftdi_tx: WR_PULSE must be 1..15");
    end

    ftdi_tx_state_t    r_state, w_state_d;
    logic [DATA_W-1:0] r_data;
    logic              r_rd_en, w_rd_en_d;
    logic [CNT_W-1:0]  r_tx_count;
    logic              r_pend_flush, r_sent;
    logic [IdleW-1:0]  r_idle_cnt;
    logic              w_commit, w_flush_done, w_auto_due, w_flush_due;
    logic              w_tmr_load, w_tmr_done;
    logic [TmrW-1:0]   w_tmr_val;

    assign w_auto_due  = (SIWU_IDLE != 0) && r_sent && (r_idle_cnt >= IdleLast);
    assign w_flush_due = r_pend_flush || w_auto_due;

    always_comb begin
        w_state_d    = r_state;
        w_commit     = 1'b0;
        w_flush_done = 1'b0;
        w_rd_en_d    = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (!empty) begin
                    w_state_d = StFetch;
                end else if (w_flush_due) begin
                    w_state_d = StFlush;
                end
            end
            StFetch: w_state_d = StLoad;
            StLoad, StWait: begin
                if (txe_n) begin
                    w_state_d = StWait;
                end else if (SETUP_CYC != 0) begin
                    w_state_d = StSetup;
                end else begin
                    w_state_d = StStrobe;
                end
            end
            StSetup: begin
                if (txe_n) begin
                    w_state_d = StWait;
                end else if (w_tmr_done) begin
                    w_state_d = StStrobe;
                end
            end
            StStrobe: begin
                // Fetch decision is registered here so rd_en in HOLD has no path from empty.
                if (w_tmr_done) begin
                    w_state_d = StHold;
                    w_commit  = 1'b1;
                    w_rd_en_d = !empty;
                end
            end
            StHold: w_state_d = r_rd_en ? StLoad : StIdle;
            StFlush: begin
                if (w_tmr_done) begin
                    w_state_d    = StIdle;
                    w_flush_done = 1'b1;
                end
            end
            default: w_state_d = StIdle;
        endcase
        if (w_state_d == StFetch) begin
            w_rd_en_d = 1'b1;
        end
    end

    // The timer is reloaded on every entry into a timed state, so SETUP restarts after WAIT.
    assign w_tmr_load = (w_state_d != r_state) &&
                        (w_state_d inside {StSetup, StStrobe, StFlush});
    assign w_tmr_val  = (w_state_d == StSetup) ? SetupLd : PulseLd;

    ftdi_tmr u_tmr (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_tmr_load),
        .i_val  (w_tmr_val),
        .o_done (w_tmr_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= StIdle;
            r_rd_en      <= 1'b0;
            r_data       <= '0;
            r_tx_count   <= '0;
            r_pend_flush <= 1'b0;
            r_sent       <= 1'b0;
            r_idle_cnt   <= '0;
        end else begin
            r_state <= w_state_d;
            r_rd_en <= w_rd_en_d;
            if (r_state == StLoad) begin
                r_data <= din;
            end
            if (w_commit) begin
                r_tx_count <= r_tx_count + 1'b1;
            end
            if (flush_req) begin
                r_pend_flush <= 1'b1;
            end else if (w_flush_done) begin
                r_pend_flush <= 1'b0;
            end
            if (w_commit) begin
                r_sent <= 1'b1;
            end else if (w_flush_done) begin
                r_sent <= 1'b0;
            end
            if (r_state != StIdle) begin
                r_idle_cnt <= '0;
            end else if (empty && (r_idle_cnt != IdleMax)) begin
                r_idle_cnt <= r_idle_cnt + 1'b1;
            end
        end
    end

    assign rd_en    = r_rd_en;
    assign wr_n     = (r_state != StStrobe);
    assign siwu_n   = (r_state != StFlush);
    assign dout_oe  = r_state inside {StWait, StSetup, StStrobe, StHold};
    assign busy     = (r_state != StIdle);
    assign tx_count = r_tx_count;
    assign dout     = dout_oe ? r_data : 'z;

endmodule

// File: tb/tb_ftdi_tx.sv
// Bench for ftdi_tx: FIFO and pad behaviour modelled at word level, directed
// timing scenarios followed by randomized traffic against a scoreboard.
module tb_ftdi_tx;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              empty;
    logic              rd_en;
    logic [DATA_W-1:0] din;
    logic              txe_n;
    logic              flush_req;
    logic              wr_n;
    logic              siwu_n;
    wire  [DATA_W-1:0] dout;
    logic              dout_oe;
    logic              busy;
    logic [CNT_W-1:0]  tx_count;

    always #5 clk = ~clk;

    ftdi_tx #(
        .DATA_W    (DATA_W),
        .SETUP_CYC (1),
        .WR_PULSE  (1),
        .SIWU_IDLE (4),
        .CNT_W     (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .empty     (empty),
        .rd_en     (rd_en),
        .din       (din),
        .txe_n     (txe_n),
        .flush_req (flush_req),
        .wr_n      (wr_n),
        .siwu_n    (siwu_n),
        .dout      (dout),
        .dout_oe   (dout_oe),
        .busy      (busy),
        .tx_count  (tx_count)
    );

    int              n_checks = 0;
    int              n_fail   = 0;
    int              cyc      = 0;
    logic [7:0]      fifo_q[$];
    logic [7:0]      exp_q[$];
    bit              prev_rd_en  = 1'b0;
    bit              prev_wr_n   = 1'b1;
    bit              prev_siwu_n = 1'b1;
    bit              flush_owed  = 1'b0;
    int              model_cnt   = 0;
    int              strb_q[$];
    logic [7:0]      data_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    task automatic push(input logic [7:0] w);
        fifo_q.push_back(w);
        empty = 1'b0;
    endtask

    // Advance one clock, model the FIFO read port, and run the always-on checks.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (prev_rd_en && fifo_q.size() != 0) begin
            din = fifo_q.pop_front();
            exp_q.push_back(din);
        end else begin
            din = 8'($urandom);
        end
        empty = (fifo_q.size() == 0);
        check("wr_siwu_excl", 32'(!wr_n && !siwu_n), 0);
        if (!wr_n) begin
            check("strobe_oe", 32'(dout_oe), 1);
            check("strobe_has_word", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) check("strobe_data", 32'(dout), 32'(exp_q[0]));
        end
        if (wr_n && !prev_wr_n) begin
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            model_cnt = (model_cnt + 1) % (1 << CNT_W);
            check("tx_count", 32'(tx_count), model_cnt);
        end
        if (!siwu_n && prev_siwu_n) flush_owed = 1'b0;
        if (rd_en) check("rd_en_safe", 32'(fifo_q.size() != 0 && exp_q.size() == 0), 1);
        prev_rd_en  = rd_en;
        prev_wr_n   = wr_n;
        prev_siwu_n = siwu_n;
    endtask

    initial begin
        rst       = 1'b1;
        empty     = 1'b1;
        din       = '0;
        txe_n     = 1'b0;
        flush_req = 1'b0;
        #12;
        check("rst_rd_en", 32'(rd_en), 0);
        check("rst_wr_n", 32'(wr_n), 1);
        check("rst_siwu_n", 32'(siwu_n), 1);
        check("rst_oe", 32'(dout_oe), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_count", 32'(tx_count), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) tick();

        // Single word, then automatic flush four idle cycles after HOLD.
        push(8'hA5);
        for (int k = 1; k <= 30; k++) begin
            tick();
            check("t1_rd_en", 32'(rd_en), 32'(k == 1));
            check("t1_wr_n", 32'(wr_n), 32'(k != 4));
            check("t1_siwu_n", 32'(siwu_n), 32'(k != 10));
            if (k >= 3 && k <= 5) begin
                check("t1_oe", 32'(dout_oe), 1);
                check("t1_dout", 32'(dout), 32'h a5);
            end
        end
        check("t1_count", 32'(tx_count), 1);

        // Back-to-back burst.
        strb_q.delete();
        data_q.delete();
        for (int i = 0; i < 8; i++) push(8'(i));
        for (int k = 1; k <= 45; k++) begin
            tick();
            if (!wr_n) begin
                strb_q.push_back(k);
                data_q.push_back(dout);
            end
        end
        check("t2_nstrobes", 32'(strb_q.size()), 8);
        for (int i = 0; i < strb_q.size() && i < 8; i++) begin
            check("t2_strobe_cyc", 32'(strb_q[i]), 32'(4 + 4 * i));
            check("t2_data", 32'(data_q[i]), 32'(i));
        end
        check("t2_count", 32'(tx_count), 9);

        // txe_n held high from FETCH: WAIT until released, then full SETUP.
        push(8'h3C);
        for (int k = 1; k <= 19; k++) begin
            tick();
            check("t3_wr_n", 32'(wr_n), 32'(k != 14));
            check("t3_busy", 32'(busy), 32'(k <= 15));
            if (k >= 3 && k <= 15) begin
                check("t3_oe", 32'(dout_oe), 1);
                check("t3_dout", 32'(dout), 32'h3c);
            end
            txe_n = (k <= 11);
        end
        repeat (6) tick();
        check("t3_count", 32'(tx_count), 10);

        // txe_n rising during SETUP restarts the setup after WAIT.
        push(8'h5A);
        for (int k = 1; k <= 20; k++) begin
            tick();
            check("t4_wr_n", 32'(wr_n), 32'(k != 6));
            if (k >= 3 && k <= 7) begin
                check("t4_oe", 32'(dout_oe), 1);
                check("t4_dout", 32'(dout), 32'h5a);
            end
            txe_n = (k == 3);
        end
        check("t4_count", 32'(tx_count), 11);

        // Flush request during the last STROBE.
        push(8'hC3);
        for (int k = 1; k <= 25; k++) begin
            tick();
            check("t5_siwu_n", 32'(siwu_n), 32'(k != 7));
            flush_req = (k == 4);
        end
        check("t5_count", 32'(tx_count), 12);

        // Asynchronous reset in the middle of STROBE.
        push(8'h99);
        for (int k = 1; k <= 4; k++) tick();
        check("t6_pre_wr_n", 32'(wr_n), 0);
        #2;
        rst = 1'b1;
        #1;
        check("t6_wr_n", 32'(wr_n), 1);
        check("t6_oe", 32'(dout_oe), 0);
        check("t6_count", 32'(tx_count), 0);
        check("t6_busy", 32'(busy), 0);
        exp_q.delete();
        model_cnt  = 0;
        prev_wr_n  = 1'b1;
        prev_rd_en = 1'b0;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("t6_no_flush", 32'(siwu_n), 1);
        end

        // Randomized traffic with stalls and flush requests.
        for (int c = 0; c < 600; c++) begin
            tick();
            txe_n     = ($urandom_range(0, 4) == 0);
            flush_req = ($urandom_range(0, 39) == 0);
            if (flush_req) flush_owed = 1'b1;
            if ($urandom_range(0, 7) == 0 && fifo_q.size() < 12) begin
                repeat ($urandom_range(1, 4)) push(8'($urandom));
            end
        end
        txe_n     = 1'b0;
        flush_req = 1'b0;
        repeat (200) tick();
        check("rand_fifo_drained", 32'(fifo_q.size()), 0);
        check("rand_all_written", 32'(exp_q.size()), 0);
        check("rand_count", 32'(tx_count), model_cnt);
        check("rand_flush_served", 32'(flush_owed), 0);
        check("rand_idle", 32'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ftdi_tx.md
# ftdi_tx

Parametrised successor to the FTDI write bridge. It drains a standard (non-FWFT, 1-cycle read latency) FIFO and writes words to an FTDI FT245-style parallel port. The word width, setup time and write-strobe width are configurable. It adds back-to-back streaming with fetch overlapped on the hold cycle, an idle-timeout and on-request send-immediate (`siwu_n`) flush, and a wrapping transfer counter. It sits between the TX FIFO and the FTDI pads in the debug/ROM-load path.

## Interface
Parameters:
- `DATA_W`, 8: FIFO/FTDI data width.
- `SETUP_CYC`, 1: cycles data is driven with `wr_n` high before the strobe. Range 0..15.
- `WR_PULSE`, 1: cycles `wr_n` is held low per word, and also the `siwu_n` pulse width. Range 1..15.
- `SIWU_IDLE`, 64: consecutive idle cycles after the last write before an automatic flush. 0 disables the automatic flush.
- `CNT_W`, 16: width of `tx_count`.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: clock.
- `rst` in 1: asynchronous active-high reset.
- `empty` in 1: FIFO empty.
- `rd_en` out 1: FIFO read strobe. `din` is valid the cycle after `rd_en`.
- `din` in DATA_W: FIFO read data.
- `txe_n` in 1: FTDI TX buffer not ready (high = cannot write).
- `flush_req` in 1: single-cycle pulse requesting a `siwu_n` flush.
- `wr_n` out 1: FTDI write strobe, active low.
- `siwu_n` out 1: FTDI send-immediate, active low.
- `dout` out DATA_W: pad data. Driven from the data register when `dout_oe`, else `'z`.
- `dout_oe` out 1: pad output enable.
- `busy` out 1: high in any state other than IDLE.
- `tx_count` out CNT_W: words written, wrapping.

## Operation
- States: IDLE, FETCH, LOAD, WAIT, SETUP, STROBE, HOLD, FLUSH.
- Reset values: state=IDLE, `rd_en`=0, `wr_n`=1, `siwu_n`=1, `dout_oe`=0, `busy`=0, `tx_count`=0, `pend_flush`=0, `sent`=0.
- IDLE:
  - If `empty`=0, go to FETCH.
  - Else, if a flush is due, go to FLUSH.
- FETCH: `rd_en`=1; go to LOAD.
- LOAD: capture `din` into the data register.
  - If `txe_n`=1, go to WAIT.
  - Else, if SETUP_CYC>0, go to SETUP.
  - Else go to STROBE.
- WAIT: `dout_oe`=1. Stay while `txe_n`=1, then proceed as from LOAD.
- SETUP: `dout_oe`=1 for SETUP_CYC cycles. If `txe_n` rises, return to WAIT and restart the setup count on re-entry.
- STROBE: `dout_oe`=1, `wr_n`=0 for WR_PULSE cycles. `txe_n` is ignored here; the write is committed. Increment `tx_count` on the last cycle and set `sent`.
- HOLD (1 cycle): `dout_oe`=1, `wr_n`=1.
  - If `empty`=0, assert `rd_en` and go to LOAD (overlapped fetch).
  - Else go to IDLE.
- Flush due when either:
  - `pend_flush`=1, or
  - SIWU_IDLE>0, `sent`=1, and the idle counter reaches SIWU_IDLE.
- Idle counter counts cycles in IDLE with `empty`=1. It clears on leaving IDLE.
- `flush_req` sets `pend_flush` in any state.
- FLUSH: `siwu_n`=0 for WR_PULSE cycles. It always completes even if `empty` falls. On exit clear `pend_flush` and `sent`, then go to IDLE.
- `tx_count` wraps from 2^CNT_W−1 to 0.
- Reset mid-operation: all outputs take their reset values immediately (asynchronous). A word already popped from the FIFO but not yet strobed is lost.

## Timing
- Example, SETUP_CYC=1, WR_PULSE=1, `txe_n`=0, `empty` falling at cycle 0:
  - FETCH at 1, LOAD at 2, SETUP at 3, STROBE at 4 (`wr_n` low), HOLD at 5.
- Streaming throughput: (2 + SETUP_CYC + WR_PULSE) cycles/word (LOAD, SETUP, STROBE, HOLD), i.e. 4 cycles/word with the defaults.
- `dout` is stable from SETUP entry through the HOLD cycle; it never changes while `wr_n`=0.
- `rd_en` is never asserted while the pad holds an unwritten word.
- `wr_n` and `siwu_n` are never low in the same cycle.
- All outputs are decoded from registered state and counters only, so there are no combinational input-to-output paths.

## Structure
- Package `ftdi_pkg`: state enum `ftdi_tx_state_t` and the width-checking localparams shared with the read-side bridge.
- Sub-module `ftdi_tmr`: 4-bit loadable down-counter with a `done` output. One instance is shared by SETUP, STROBE and FLUSH, which never overlap in time. The idle counter is a separate `$clog2(SIWU_IDLE+1)`-bit counter in the top.
- Elaboration checks: SETUP_CYC ≤ 15; 1 ≤ WR_PULSE ≤ 15.

## Test plan
- Single word 0xA5, `txe_n`=0, defaults → one `rd_en` at cycle 1, `wr_n` low at cycle 4 only, `dout`=0xA5 during cycles 3–5, `tx_count`=1.
- 8-word burst 0x00..0x07 with `empty` held low → strobes exactly every 4 cycles, in order, `tx_count`=8.
- `txe_n` high during LOAD for 10 cycles, then low → stays in WAIT, `wr_n` high, `dout` held. Then full SETUP followed by STROBE.
- `txe_n` rises during SETUP → returns to WAIT. The strobe occurs only after a fresh SETUP_CYC count.
- SIWU_IDLE=4, one word sent then FIFO empty → `siwu_n` low exactly once, 4 idle cycles after HOLD. No second flush until another word is sent.
- `flush_req` pulsed during STROBE of the last word → FLUSH follows the resulting IDLE entry. Also check `rst` asserted mid-STROBE: `wr_n`=1 and `dout_oe`=0 in the same cycle, and `tx_count`=0.
